// File: rtl/array_multiplier.sv
// rtl/array_multiplier.sv - registered unsigned structural array multiplier
//
// Purpose: full-precision unsigned product of two Width-bit operands. It is
// built from a partial-product AND array, carry-save rows of adder cells and
// a final ripple-carry row. The result is captured in a 2*Width register.
// Latency is one cycle, with one product per cycle.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset; clears data_out_o
//   data_in1_i  [Width-1:0]   unsigned multiplicand
//   data_in2_i  [Width-1:0]   unsigned multiplier
//   data_out_o  [2*Width-1:0] registered product

module array_multiplier_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module array_multiplier_ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i;
  assign co_o = a_i & b_i;
endmodule

module array_multiplier #(
  parameter int Width = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [Width-1:0]   data_in1_i,
  input  logic [Width-1:0]   data_in2_i,
  output logic [2*Width-1:0] data_out_o
);

  // pp[i][j] has weight i+j.
  // In row i, sum_w[i][j] has weight i+j and carry_w[i][j] has weight i+j+1.
  logic [Width-1:0][Width-1:0] pp;
  logic [Width-1:0][Width-1:0] sum_w;
  logic [Width-1:0][Width-1:0] carry_w;
  logic [Width-1:0]            rip_c;   // ripple carry into final-row bit k
  logic [2*Width-1:0]          product_d;
  logic [2*Width-1:0]          product_q;

  for (genvar i = 0; i < Width; i++) begin : g_pp_row
    for (genvar j = 0; j < Width; j++) begin : g_pp_col
      assign pp[i][j] = data_in1_i[j] & data_in2_i[i];
    end
  end

  // Row 0 is the first partial product itself and carries nothing.
  assign sum_w[0]   = pp[0];
  assign carry_w[0] = '0;

  // Each row adds its partial-product bit to the previous row's sum.
  // That sum comes from one column to the left, which has the same weight.
  // The previous row's carry from the same column is added as well.
  // The top column has no sum from the left, so a half adder is enough there.
  for (genvar i = 1; i < Width; i++) begin : g_row
    for (genvar j = 0; j < Width; j++) begin : g_col
      if (j < Width - 1) begin : g_fa
        array_multiplier_fa u_fa (
          .a_i (pp[i][j]),
          .b_i (sum_w[i-1][j+1]),
          .c_i (carry_w[i-1][j]),
          .s_o (sum_w[i][j]),
          .co_o(carry_w[i][j])
        );
      end else begin : g_ha
        array_multiplier_ha u_ha (
          .a_i (pp[i][j]),
          .b_i (carry_w[i-1][j]),
          .s_o (sum_w[i][j]),
          .co_o(carry_w[i][j])
        );
      end
    end
  end

  // Bit 0 of each row's sum is final, so it gives the low half of the product.
  for (genvar i = 0; i < Width; i++) begin : g_low
    assign product_d[i] = sum_w[i][0];
  end

  // Final ripple row resolves the carry-save remainder into the upper half.
  assign rip_c[0] = 1'b0;
  for (genvar k = 0; k < Width - 1; k++) begin : g_rip
    if (k == 0) begin : g_ha0
      array_multiplier_ha u_ha (
        .a_i (sum_w[Width-1][1]),
        .b_i (carry_w[Width-1][0]),
        .s_o (product_d[Width]),
        .co_o(rip_c[1])
      );
    end else begin : g_fak
      array_multiplier_fa u_fa (
        .a_i (sum_w[Width-1][k+1]),
        .b_i (carry_w[Width-1][k]),
        .c_i (rip_c[k]),
        .s_o (product_d[Width+k]),
        .co_o(rip_c[k+1])
      );
    end
  end

  // The product always fits in 2*Width bits.
  // The carry out of the top bit is therefore always zero and is not formed.
  assign product_d[2*Width-1] = carry_w[Width-1][Width-1] ^ rip_c[Width-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign data_out_o = product_q;

endmodule

// File: tb/tb_array_multiplier.sv
// tb/tb_array_multiplier.sv - self-checking bench for array_multiplier

module tb_array_multiplier;

  localparam int Width = 8;

  logic               clk;
  logic               rst;
  logic [Width-1:0]   in1;
  logic [Width-1:0]   in2;
  logic [2*Width-1:0] dout;

  int n_cmp;
  int n_bad;

  array_multiplier #(.Width(Width)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .data_in1_i(in1),
    .data_in2_i(in2),
    .data_out_o(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in1 = 8'd37;
    in2 = 8'd91;
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d expected 0", dout);
    end
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %0d expected 0", dout);
    end
  endtask

  task automatic test_first_edge();
    // The first edge after reset is released already captures the product.
    rst = 1'b0;
    in1 = 8'd2;
    in2 = 8'd7;
    step();
    n_cmp++;
    if (dout !== 16'd14) begin
      n_bad++;
      $display("FAIL basic_2x7: got %0d expected 14", dout);
    end
  endtask

  task automatic test_back_to_back();
    in1 = 8'd211;
    in2 = 8'd98;
    step();
    n_cmp++;
    if (dout !== 16'd20678) begin
      n_bad++;
      $display("FAIL b2b_211x98: got %0d expected 20678", dout);
    end
    in1 = 8'd123;
    in2 = 8'd77;
    step();
    n_cmp++;
    if (dout !== 16'd9471) begin
      n_bad++;
      $display("FAIL b2b_123x77: got %0d expected 9471", dout);
    end
    in1 = 8'd3;
    in2 = 8'd5;
    step();
    n_cmp++;
    if (dout !== 16'd15) begin
      n_bad++;
      $display("FAIL b2b_3x5: got %0d expected 15", dout);
    end
  endtask

  task automatic test_zero();
    in1 = 8'd0;
    in2 = 8'd0;
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_0x0: got %0d expected 0", dout);
    end
    in1 = 8'd0;
    in2 = 8'd255;
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_0x255: got %0d expected 0", dout);
    end
    in1 = 8'd255;
    in2 = 8'd0;
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL zero_255x0: got %0d expected 0", dout);
    end
  endtask

  task automatic test_max();
    in1 = 8'd255;
    in2 = 8'd255;
    step();
    n_cmp++;
    if (dout !== 16'd65025) begin
      n_bad++;
      $display("FAIL max_255x255: got %0d expected 65025", dout);
    end
    in1 = 8'd128;
    in2 = 8'd255;
    step();
    n_cmp++;
    if (dout !== 16'd32640) begin
      n_bad++;
      $display("FAIL max_128x255: got %0d expected 32640", dout);
    end
  endtask

  task automatic test_reset_midstream();
    in1 = 8'd255;
    in2 = 8'd255;
    step();
    n_cmp++;
    if (dout !== 16'd65025) begin
      n_bad++;
      $display("FAIL mid_before: got %0d expected 65025", dout);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (dout !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got %0d expected 0", dout);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (dout !== 16'd65025) begin
      n_bad++;
      $display("FAIL mid_release: got %0d expected 65025", dout);
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] expv;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        in1 = a[7:0];
        in2 = b[7:0];
        expv = 16'(a * b);
        step();
        n_cmp++;
        if (dout !== expv) begin
          n_bad++;
          $display("FAIL exhaustive %0dx%0d: got %0d expected %0d", a, b, dout, expv);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] expv;
    int unsigned ra;
    int unsigned rb;
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      in1 = ra[7:0];
      in2 = rb[7:0];
      expv = 16'(ra * rb);
      step();
      n_cmp++;
      if (dout !== expv) begin
        n_bad++;
        $display("FAIL random %0dx%0d: got %0d expected %0d", ra, rb, dout, expv);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    in1   = '0;
    in2   = '0;
    test_reset();
    test_first_edge();
    test_back_to_back();
    test_zero();
    test_max();
    test_reset_midstream();
    test_exhaustive();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/array_multiplier.md
ARRAY_MULTIPLIER -- requirements
Module: array_multiplier

Interface
REQ-001 Parameter: Width, default 8, operand width in bits; SHALL be legal for any value >= 2.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 data_in1_i  input  Width  unsigned multiplicand.
REQ-005 data_in2_i  input  Width  unsigned multiplier.
REQ-006 data_out_o  output  2*Width  unsigned product, registered.

Function
REQ-007 Block SHALL compute the full-precision unsigned product data_in1_i * data_in2_i; no truncation, no saturation, no overflow possible in 2*Width bits.
REQ-008 Datapath SHALL be a structural array multiplier:
  - Width x Width partial-product AND array (pp[i][j] = in1[j] & in2[i]).
  - Rows of full/half adders reducing partial products, one row per multiplier bit, carries passed to the next row.
  - Final ripple-carry row producing the upper product bits.
  - The behavioural '*' operator SHALL NOT be used.
REQ-009 Full adder and half adder SHALL be plain combinational cells (sum = a^b^c, carry = majority), generated by loops over Width.
REQ-010 Array output SHALL be captured in a 2*Width output register on every rising clk_i edge; data_out_o is driven only by that register.
REQ-011 Latency SHALL be exactly 1 cycle: inputs stable at rising edge N give their product on data_out_o from edge N until edge N+1.
REQ-012 Throughput SHALL be one product per cycle; no handshake, no valid/ready; inputs may change every cycle.
REQ-013 Combinational path inputs-to-register SHALL close timing at 20 MHz for Width = 8.
REQ-014 Boundary values: 0 x anything = 0; (2^Width-1)^2 = 2^(2*Width) - 2^(Width+1) + 1 (65025 for Width 8), all carries propagated.
REQ-015 Unknown/X on inputs is outside scope; no X-masking logic required.

Reset
REQ-016 While rst_i is high at a rising edge, data_out_o SHALL load 0, regardless of inputs.
REQ-017 Reset has priority over the product capture on the same edge.
REQ-018 First edge with rst_i low SHALL capture the current inputs' product (normal operation, no extra recovery cycle).
REQ-019 Asserting rst_i mid-stream SHALL clear data_out_o at that edge; no other state exists.

Verification
REQ-020 in1=2, in2=7, one edge -> data_out_o = 14.
REQ-021 in1=211, in2=98 -> 20678; in1=123, in2=77 -> 9471, applied back-to-back on consecutive cycles, each visible exactly one edge after application.
REQ-022 in1=0, in2=0 -> 0; in1=0, in2=255 -> 0.
REQ-023 in1=255, in2=255 -> 65025 (full carry chain exercised).
REQ-024 Hold in1=255, in2=255, assert rst_i for one edge -> data_out_o = 0 at that edge; deassert -> 65025 at the next edge.
REQ-025 Random sweep (>= 10000 pairs, plus exhaustive 65536 pairs for Width=8) compared against a reference model with 1-cycle delay -> zero mismatches.
